pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel 4-bit PWM. All channels share one period counter. The period, the mode and each per-channel duty are double-buffered: written into shadow registers at any time, and applied only at a period boundary, so no output ever sees a glitched or truncated cycle. Supports edge-aligned and center-aligned modes and sits beside the ALU as the LED/actuator driver.

---
 rtl/pwm_multi_ch.sv | 118 +++++++++++
 tb/tb_pwm_multi_ch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty
// compare, double-buffered period/duty/mode that take effect at a period boundary.
`timescale 1ns/1ps
module pwm_multi_ch #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              enable,
    input  logic                              center,
    input  logic                              wr_en,
    input  logic [$clog2(CHANNELS+1)-1:0]     wr_addr,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic [CHANNELS-1:0]               pwm_out,
    output logic                              period_start,
    output logic [WIDTH-1:0]                  count
);

    localparam int unsigned AW = $clog2(CHANNELS + 1);

    logic [WIDTH-1:0] period_sh;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] period_nx;
    logic [WIDTH-1:0] duty_sh  [CHANNELS];
    logic [WIDTH-1:0] duty_act [CHANNELS];
    logic [WIDTH-1:0] duty_nx  [CHANNELS];
    logic             mode_act;
    logic             dir_down;
    logic [WIDTH-1:0] count_nx;
    logic             dir_nx;
    logic             last_up;
    logic             boundary;
    logic             load;

    // Shadow values as they will be after this edge's write (also the bypass path)
    always_comb begin
        period_nx = period_sh;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            duty_nx[i] = duty_sh[i];
        end
        if (wr_en && (wr_addr == '0)) begin
            period_nx = wr_data;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_addr == AW'(i + 1))) begin
                duty_nx[i] = wr_data;
            end
        end
    end

    // Boundary detection and next counter value; center is the always-written shadow mode
    always_comb begin
        last_up  = (count == period_act);
        boundary = 1'b0;
        count_nx = count;
        dir_nx   = dir_down;
        if (!mode_act) begin
            boundary = last_up;
        end else begin
            boundary = (dir_down && (count == WIDTH'(1))) ||
                       (!dir_down && last_up && (period_act <= WIDTH'(1)));
        end
        load = !enable || boundary;
        if (load) begin
            count_nx = '0;
            dir_nx   = 1'b0;
        end else if (!mode_act) begin
            count_nx = count + WIDTH'(1);
        end else if (!dir_down) begin
            if (last_up) begin
                count_nx = count - WIDTH'(1);
                dir_nx   = 1'b1;
            end else begin
                count_nx = count + WIDTH'(1);
            end
        end else begin
            count_nx = count - WIDTH'(1);
        end
    end

    // Shadow, active, counter and output compare registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_sh  <= '1;
            period_act <= '1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
            mode_act <= 1'b0;
            dir_down <= 1'b0;
            count    <= '0;
            pwm_out  <= '0;
        end else begin
            period_sh <= period_nx;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh[i] <= duty_nx[i];
            end
            if (load) begin
                period_act <= period_nx;
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    duty_act[i] <= duty_nx[i];
                end
                mode_act <= center;
            end
            count    <= count_nx;
            dir_down <= dir_nx;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= enable && (count < duty_act[i]);
            end
        end
    end

    // First cycle of a period; forced low while reset is held
    assign period_start = resetn && enable && (count == '0) && !dir_down;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized bench for pwm_multi_ch against a period-position reference model.
`timescale 1ns/1ps
module tb_pwm_multi_ch;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          center = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [W-1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the period instead of a direction flag
    int       mp_sh, mp_act;
    int       md_sh[CH];
    int       md_act[CH];
    bit       mm_act;
    int       pos;
    bit [CH-1:0] mpwm;

    pwm_multi_ch #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .center(center),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pwm_out(pwm_out), .period_start(period_start), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int plen(input int p, input bit m);
        if (p == 0) return 1;
        return m ? 2 * p : p + 1;
    endfunction

    function automatic int pcnt(input int ps, input int p, input bit m);
        if (m && ps > p) return 2 * p - ps;
        return ps;
    endfunction

    function automatic int mcount();
        return pcnt(pos, mp_act, mm_act);
    endfunction

    task automatic model_reset();
        mp_sh = 255; mp_act = 255;
        for (int i = 0; i < CH; i++) begin
            md_sh[i] = 0; md_act[i] = 0;
        end
        mm_act = 1'b0; pos = 0; mpwm = '0;
    endtask

    // One clock: drive at negedge, check period_start, advance model, check registered outputs
    task automatic step(input bit e, input bit c, input bit w, input int a, input int d);
        int sp;
        int sd[CH];
        int cur;
        @(negedge clk);
        enable = e; center = c; wr_en = w;
        wr_addr = 3'(a); wr_data = W'(d);
        #1;
        check("period_start", 32'(period_start), 32'(e && pos == 0));
        @(posedge clk);
        cur = mcount();
        sp = mp_sh;
        for (int i = 0; i < CH; i++) sd[i] = md_sh[i];
        if (w) begin
            if (a == 0) sp = d;
            else if (a <= CH) sd[a-1] = d;
        end
        for (int i = 0; i < CH; i++) mpwm[i] = e && (cur < md_act[i]);
        if (!e || pos == plen(mp_act, mm_act) - 1) begin
            pos = 0; mp_act = sp; mm_act = c;
            for (int i = 0; i < CH; i++) md_act[i] = sd[i];
        end else begin
            pos++;
        end
        mp_sh = sp;
        for (int i = 0; i < CH; i++) md_sh[i] = sd[i];
        #1;
        check("count", 32'(count), 32'(mcount()));
        check("pwm_out", 32'(pwm_out), 32'(mpwm));
    endtask

    task automatic run(input int n, input bit e, input bit c);
        for (int i = 0; i < n; i++) step(e, c, 1'b0, 0, 0);
    endtask

    task automatic wr(input int a, input int d, input bit c);
        step(1'b1, c, 1'b1, a, d);
    endtask

    task automatic wait_cnt(input int target, input bit c);
        int k;
        k = 0;
        while (mcount() != target && k < 600) begin
            step(1'b1, c, 1'b0, 0, 0);
            k++;
        end
        if (k >= 600) check("wait_timeout", 32'(count), 32'(target));
    endtask

    // Asynchronous reset mid-run, released away from a clock edge
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    bit rc;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_count", 32'(count), 32'd0);
        check("init_pwm", 32'(pwm_out), 32'd0);
        resetn = 1'b1;

        // Default period 255 counts all the way up
        run(300, 1'b1, 1'b0);
        wr(1, 3, 1'b0);
        run(37, 1'b1, 1'b0);
        do_reset();
        run(5, 1'b1, 1'b0);

        // Edge mode P=9, duty0=3, then duty bounds
        wr(0, 9, 1'b0);
        wr(1, 3, 1'b0);
        run(40, 1'b1, 1'b0);
        wr(2, 0, 1'b0);
        wr(3, 10, 1'b0);
        wr(4, 200, 1'b0);
        run(30, 1'b1, 1'b0);

        // Double buffering: mid-period write waits, write at count==P is bypassed
        wr(1, 2, 1'b0);
        run(12, 1'b1, 1'b0);
        wait_cnt(4, 1'b0);
        wr(1, 5, 1'b0);
        wait_cnt(9, 1'b0);
        wr(1, 7, 1'b0);
        run(25, 1'b1, 1'b0);

        // Center mode P=4, duty0=2
        wr(0, 4, 1'b1);
        wr(1, 2, 1'b1);
        run(30, 1'b1, 1'b1);

        // Mode switch raised mid edge period
        wr(0, 9, 1'b0);
        run(20, 1'b1, 1'b0);
        wait_cnt(5, 1'b0);
        run(40, 1'b1, 1'b1);

        // Disable and re-enable
        run(10, 1'b0, 1'b1);
        run(10, 1'b1, 1'b1);

        // P=0 degenerate period
        wr(0, 0, 1'b0);
        wr(1, 1, 1'b0);
        run(20, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1);

        // Out-of-range address must be ignored
        wr(0, 6, 1'b0);
        wr(5, 3, 1'b0);
        wr(7, 3, 1'b0);
        run(20, 1'b1, 1'b0);

        // Random traffic
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit e, w;
            int a, d;
            if ($urandom_range(0, 39) == 0) rc = ~rc;
            e = ($urandom_range(0, 24) != 0);
            w = ($urandom_range(0, 5) == 0);
            a = $urandom_range(0, 7);
            d = (a == 0) ? $urandom_range(0, 12) : $urandom_range(0, 15);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(e, rc, w, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
